id_ex_control: RTL and testbench

ID_EX_CONTROL -- requirements
Module: id_ex_control

---
 rtl/id_ex_control_pkg.sv | 36 +++
 rtl/id_ex_control_main_decoder.sv | 52 +++++
 rtl/id_ex_control.sv | 114 +++++++++++
 tb/tb_id_ex_control.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_control_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_control_pkg
// Shared decode vocabulary for the ID stage and the ALU control decoder:
// opcode constants, ALUop encodings and the packed control bundle that
// travels from the main decoder into the ID/EX pipeline register.
// ---------------------------------------------------------------------------
package id_ex_control_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;

   typedef struct packed {
      logic   regdst;
      logic   alusrc;
      logic   memtoreg;
      logic   regwrite;
      logic   memread;
      logic   memwrite;
      logic   branch;
      logic   illegal;
      aluop_e aluop;
   } ctrl_t;

   // All-zero control word: what a bubble carries down the pipe.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_control_main_decoder.sv
// ---------------------------------------------------------------------------
// main_decoder
// Purely combinational opcode decode for the ID stage.
// Ports:
//   opcode : in  [OP_W-1:0]  instruction opcode field
//   ctrl   : out ctrl_t      decoded control bundle (illegal=1 for unknown)
// ---------------------------------------------------------------------------
module main_decoder
   import id_ex_control_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] opcode,
   output ctrl_t           ctrl
);

   always_comb begin
      ctrl = CTRL_BUBBLE;
      case (opcode)
         OP_W'(OPC_RTYPE): begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALUOP_FUNCT;
         end
         OP_W'(OPC_LW): begin
            ctrl.alusrc   = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.memread  = 1'b1;
            ctrl.aluop    = ALUOP_ADD;
         end
         OP_W'(OPC_SW): begin
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.aluop    = ALUOP_ADD;
         end
         OP_W'(OPC_BEQ): begin
            ctrl.branch   = 1'b1;
            ctrl.aluop    = ALUOP_SUB;
         end
         OP_W'(OPC_ADDI): begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = ALUOP_ADD;
         end
         default: begin
            ctrl.illegal  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ex_control.sv
// ---------------------------------------------------------------------------
// id_ex_control
// ID-stage control: decodes the IF/ID instruction, detects load-use hazards,
// and registers control plus operand specifiers into the ID/EX stage.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   opcode, funct         : in  [OP_W-1:0]  IF/ID instruction fields
//   rs, rt, rd            : in  [REG_W-1:0] IF/ID register specifiers
//   if_id_valid           : in  IF/ID holds a real instruction
//   flush                 : in  taken branch, kill the ID instruction
//   ex_valid .. ex_illegal: out registered ID/EX control bits
//   ex_aluop              : out [1:0] registered ALUop
//   ex_funct, ex_rs/rt/rd : out registered instruction fields
//   stall                 : out combinational freeze of PC and IF/ID
//   stall_cnt             : out [15:0] saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_ex_control
   import id_ex_control_pkg::*;
#(
   parameter int OP_W  = 6,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OP_W-1:0]  opcode,
   input  logic [OP_W-1:0]  funct,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic [REG_W-1:0] rd,
   input  logic             if_id_valid,
   input  logic             flush,
   output logic             ex_valid,
   output logic             ex_regdst,
   output logic             ex_alusrc,
   output logic             ex_memtoreg,
   output logic             ex_regwrite,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_branch,
   output logic             ex_illegal,
   output logic [1:0]       ex_aluop,
   output logic [OP_W-1:0]  ex_funct,
   output logic [REG_W-1:0] ex_rs,
   output logic [REG_W-1:0] ex_rt,
   output logic [REG_W-1:0] ex_rd,
   output logic             stall,
   output logic [15:0]      stall_cnt
);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   ctrl_t dec_ctrl;
   ctrl_t ex_ctrl;
   logic  rt_is_src;
   logic  bubble;

   main_decoder #(.OP_W(OP_W)) u_main_decoder (
      .opcode (opcode),
      .ctrl   (dec_ctrl)
   );

   // rt is a source operand only for R-type, sw and beq; for lw/addi it is
   // the destination and cannot create a load-use dependency.
   assign rt_is_src = (opcode == OP_W'(OPC_RTYPE)) ||
                      (opcode == OP_W'(OPC_SW))    ||
                      (opcode == OP_W'(OPC_BEQ));

   // Flush kills the ID instruction, so there is nothing left to stall for.
   assign stall = !flush && if_id_valid && ex_valid && ex_memread &&
                  (ex_rt != '0) &&
                  ((ex_rt == rs) || ((ex_rt == rt) && rt_is_src));

   assign bubble = flush || stall || !if_id_valid;

   // ---- ID -> EX stage boundary ----
   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= CTRL_BUBBLE;
         ex_funct <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_rd    <= '0;
      end else begin
         ex_valid <= 1'b1;
         ex_ctrl  <= dec_ctrl;
         ex_funct <= funct;
         ex_rs    <= rs;
         ex_rt    <= rt;
         ex_rd    <= rd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign ex_regdst   = ex_ctrl.regdst;
   assign ex_alusrc   = ex_ctrl.alusrc;
   assign ex_memtoreg = ex_ctrl.memtoreg;
   assign ex_regwrite = ex_ctrl.regwrite;
   assign ex_memread  = ex_ctrl.memread;
   assign ex_memwrite = ex_ctrl.memwrite;
   assign ex_branch   = ex_ctrl.branch;
   assign ex_illegal  = ex_ctrl.illegal;
   assign ex_aluop    = ex_ctrl.aluop;

endmodule

// File: tb/tb_id_ex_control.sv
// ---------------------------------------------------------------------------
// tb_id_ex_control
// Scoreboard bench: the driver pushes the hand-computed outputs expected in
// each checked cycle; a monitor pops and compares on the falling edge.
// Control vector order: {regdst,alusrc,memtoreg,regwrite,memread,memwrite,
// branch,illegal}.
// ---------------------------------------------------------------------------
module tb_id_ex_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic [4:0] rs, rt, rd;
   logic       if_id_valid, flush;
   logic       ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite;
   logic       ex_memread, ex_memwrite, ex_branch, ex_illegal;
   logic [1:0] ex_aluop;
   logic [5:0] ex_funct;
   logic [4:0] ex_rs, ex_rt, ex_rd;
   logic       stall;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       nm;
      logic        st;
      logic [15:0] cnt;
      logic        v;
      logic [7:0]  c;
      logic [1:0]  a;
      logic [5:0]  f;
      logic [4:0]  s, t, d;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   id_ex_control #(.OP_W(6), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .rs(rs), .rt(rt), .rd(rd), .if_id_valid(if_id_valid), .flush(flush),
      .ex_valid(ex_valid), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
      .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_branch(ex_branch), .ex_illegal(ex_illegal), .ex_aluop(ex_aluop),
      .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .stall(stall), .stall_cnt(stall_cnt)
   );

   function automatic void chk(input string nm, input string fld,
                               input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
      end
   endfunction

   // Monitor: compares the DUT against the oldest pending expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.nm, "stall",     int'(stall),     int'(e.st));
         chk(e.nm, "stall_cnt", int'(stall_cnt), int'(e.cnt));
         chk(e.nm, "ex_valid",  int'(ex_valid),  int'(e.v));
         chk(e.nm, "ctrl",
             int'({ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
                   ex_memread, ex_memwrite, ex_branch, ex_illegal}),
             int'(e.c));
         chk(e.nm, "ex_aluop",  int'(ex_aluop),  int'(e.a));
         chk(e.nm, "ex_funct",  int'(ex_funct),  int'(e.f));
         chk(e.nm, "ex_rs",     int'(ex_rs),     int'(e.s));
         chk(e.nm, "ex_rt",     int'(ex_rt),     int'(e.t));
         chk(e.nm, "ex_rd",     int'(ex_rd),     int'(e.d));
      end
   end

   task automatic drive(input logic [5:0] op, input logic [5:0] f,
                        input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic v, input logic fl);
      opcode = op; funct = f; rs = s; rt = t; rd = d;
      if_id_valid = v; flush = fl;
   endtask

   task automatic nop();
      drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic expect_out(input string nm, input logic st,
                             input logic [15:0] cnt, input logic v,
                             input logic [7:0] c, input logic [1:0] a,
                             input logic [5:0] f, input logic [4:0] s,
                             input logic [4:0] t, input logic [4:0] d);
      exp_t e;
      e.nm = nm; e.st = st; e.cnt = cnt; e.v = v; e.c = c; e.a = a;
      e.f = f; e.s = s; e.t = t; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic expect_bubble(input string nm, input logic st,
                                input logic [15:0] cnt);
      expect_out(nm, st, cnt, 1'b0, 8'h00, 2'b00, 6'h00, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      reset = 1'b1;
      nop();
      tick();
      expect_bubble("reset", 1'b0, 16'd0);
      tick();

      // R-type add rs=1 rt=2 rd=3
      reset = 1'b0;
      drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      expect_bubble("post_reset", 1'b0, 16'd0);
      tick();
      nop();
      expect_out("add_ex", 1'b0, 16'd0, 1'b1, 8'h90, 2'b10, 6'h20, 5'd1, 5'd2, 5'd3);
      tick();

      // lw rt=5 then add rs=5: one stall, one bubble
      drive(6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0);
      expect_bubble("idle1", 1'b0, 16'd0);
      tick();
      drive(6'h00, 6'h20, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
      expect_out("lu_stall", 1'b1, 16'd0, 1'b1, 8'h78, 2'b00, 6'h00, 5'd1, 5'd5, 5'd0);
      tick();
      expect_bubble("lu_bubble", 1'b0, 16'd1);
      tick();
      nop();
      expect_out("lu_add_ex", 1'b0, 16'd1, 1'b1, 8'h90, 2'b10, 6'h20, 5'd5, 5'd6, 5'd7);
      tick();

      // lw rt=0 then add rs=0: no hazard on $zero
      drive(6'h23, 6'h00, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0);
      expect_bubble("idle2", 1'b0, 16'd1);
      tick();
      drive(6'h00, 6'h20, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0);
      expect_out("zero_lw", 1'b0, 16'd1, 1'b1, 8'h78, 2'b00, 6'h00, 5'd2, 5'd0, 5'd0);
      tick();
      nop();
      expect_out("zero_add", 1'b0, 16'd1, 1'b1, 8'h90, 2'b10, 6'h20, 5'd0, 5'd3, 5'd4);
      tick();

      // lw rt=4 then addi rs=7 rt=4: rt is a destination, no stall
      drive(6'h23, 6'h00, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0);
      expect_bubble("idle3", 1'b0, 16'd1);
      tick();
      drive(6'h08, 6'h00, 5'd7, 5'd4, 5'd0, 1'b1, 1'b0);
      expect_out("addi_nostall", 1'b0, 16'd1, 1'b1, 8'h78, 2'b00, 6'h00, 5'd1, 5'd4, 5'd0);
      tick();

      // lw rt=9 then beq rt=9 with flush: flush wins
      drive(6'h23, 6'h00, 5'd1, 5'd9, 5'd0, 1'b1, 1'b0);
      expect_out("addi_ex", 1'b0, 16'd1, 1'b1, 8'h50, 2'b00, 6'h00, 5'd7, 5'd4, 5'd0);
      tick();
      drive(6'h04, 6'h00, 5'd3, 5'd9, 5'd0, 1'b1, 1'b1);
      expect_out("flush_nostall", 1'b0, 16'd1, 1'b1, 8'h78, 2'b00, 6'h00, 5'd1, 5'd9, 5'd0);
      tick();

      // illegal opcode 111111
      drive(6'h3F, 6'h05, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
      expect_bubble("flush_bubble", 1'b0, 16'd1);
      tick();
      nop();
      expect_out("illegal_ex", 1'b0, 16'd1, 1'b1, 8'h01, 2'b00, 6'h05, 5'd0, 5'd0, 5'd1);
      tick();

      // lw rt=6 then sw rt=6: rt is a source for sw, stall
      drive(6'h23, 6'h00, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0);
      expect_bubble("idle4", 1'b0, 16'd1);
      tick();
      drive(6'h2B, 6'h00, 5'd1, 5'd6, 5'd0, 1'b1, 1'b0);
      expect_out("sw_stall", 1'b1, 16'd1, 1'b1, 8'h78, 2'b00, 6'h00, 5'd0, 5'd6, 5'd0);
      tick();
      expect_bubble("sw_bubble", 1'b0, 16'd2);
      tick();
      nop();
      expect_out("sw_ex", 1'b0, 16'd2, 1'b1, 8'h44, 2'b00, 6'h00, 5'd1, 5'd6, 5'd0);
      tick();

      // 65540 consecutive forced stalls saturate the counter
      force dut.stall = 1'b1;
      for (int i = 0; i < 65540; i++) tick();
      expect_bubble("cnt_sat", 1'b1, 16'hFFFF);
      tick();
      release dut.stall;

      // real hazard with reset asserted mid-stall
      drive(6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0);
      expect_bubble("sat_hold", 1'b0, 16'hFFFF);
      tick();
      drive(6'h00, 6'h20, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0);
      reset = 1'b1;
      expect_out("pre_reset_stall", 1'b1, 16'hFFFF, 1'b1, 8'h78, 2'b00, 6'h00, 5'd0, 5'd5, 5'd0);
      tick();
      reset = 1'b0;
      expect_bubble("mid_stall_reset", 1'b0, 16'd0);
      tick();
      nop();
      expect_out("post_reset_add", 1'b0, 16'd0, 1'b1, 8'h90, 2'b10, 6'h20, 5'd5, 5'd1, 5'd2);
      tick();

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
